// File: rtl/uart_cmd_parser.sv
// Command parser between a UART receiver and transmitter: assembles 5-byte frames
// (55 CMD ADDR DATA CHK), drives a local register port and paces 1-2 byte responses.
module uart_cmd_parser #(
   parameter int TX_GAP_CYCLES  = 52080,
   parameter int TIMEOUT_CYCLES = 520800
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       uart_rx_done,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic [7:0] frame_err_cnt
);

   localparam int GAP_W = $clog2(TX_GAP_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TX_GAP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] HEADER   = 8'h55;
   localparam logic [7:0] CMD_WR   = 8'h01;
   localparam logic [7:0] CMD_RD   = 8'h02;
   localparam logic [7:0] RSP_WR   = 8'hA0;
   localparam logic [7:0] RSP_RD   = 8'hA1;
   localparam logic [7:0] RSP_ERR  = 8'hEE;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RD, S_TX_GAP
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic [7:0]       txData_q, txData_d;
   logic             txStart_q, txStart_d;
   logic [7:0]       pend_q, pend_d;
   logic             pendValid_q, pendValid_d;
   logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
   logic [TO_W-1:0]  toCnt_q, toCnt_d;
   logic [7:0]       errCnt_q, errCnt_d;
   logic             errEvent;
   logic             frameOk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         txData_q    <= '0;
         txStart_q   <= 1'b0;
         pend_q      <= '0;
         pendValid_q <= 1'b0;
         gapCnt_q    <= '0;
         toCnt_q     <= '0;
         errCnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         txData_q    <= txData_d;
         txStart_q   <= txStart_d;
         pend_q      <= pend_d;
         pendValid_q <= pendValid_d;
         gapCnt_q    <= gapCnt_d;
         toCnt_q     <= toCnt_d;
         errCnt_q    <= errCnt_d;
      end
   end

   assign frameOk = (rx_data == (cmd_q ^ addr_q ^ data_q)) &&
                    ((cmd_q == CMD_WR) || (cmd_q == CMD_RD));

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      data_d      = data_q;
      valid_d     = valid_q;
      txData_d    = txData_q;
      txStart_d   = 1'b0;
      pend_d      = pend_q;
      pendValid_d = pendValid_q;
      gapCnt_d    = gapCnt_q;
      toCnt_d     = '0;
      errEvent    = 1'b0;
      reg_we      = 1'b0;
      reg_re      = 1'b0;

      // Frame-collection states share one inter-byte timeout; a byte restarts it at 1
      // so that the return to IDLE lands exactly TIMEOUT_CYCLES after that byte.
      if (state_q inside {S_CMD, S_ADDR, S_DATA, S_CHK}) begin
         if (uart_rx_done) begin
            toCnt_d = TO_W'(1);
         end else if (toCnt_q == TO_LAST) begin
            state_d  = S_IDLE;
            errEvent = 1'b1;
         end else begin
            toCnt_d = toCnt_q + TO_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (uart_rx_done && (rx_data == HEADER)) begin
               state_d = S_CMD;
               toCnt_d = TO_W'(1);
            end
         end
         S_CMD: begin
            if (uart_rx_done) begin
               cmd_d   = rx_data;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (uart_rx_done) begin
               addr_d  = rx_data;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (uart_rx_done) begin
               data_d  = rx_data;
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (uart_rx_done) begin
               valid_d  = frameOk;
               errEvent = !frameOk;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            txStart_d = 1'b1;
            gapCnt_d  = '0;
            state_d   = S_TX_GAP;
            if (valid_q && (cmd_q == CMD_RD)) begin
               reg_re   = 1'b1;
               txData_d = RSP_RD;
               state_d  = S_RD;
            end else if (valid_q) begin
               reg_we   = 1'b1;
               txData_d = RSP_WR;
            end else begin
               txData_d = RSP_ERR;
            end
         end
         S_RD: begin
            pend_d      = reg_rdata;
            pendValid_d = 1'b1;
            gapCnt_d    = gapCnt_q + GAP_W'(1);
            state_d     = S_TX_GAP;
         end
         S_TX_GAP: begin
            if (gapCnt_q == GAP_LAST) begin
               if (pendValid_q) begin
                  txStart_d   = 1'b1;
                  txData_d    = pend_q;
                  pendValid_d = 1'b0;
                  gapCnt_d    = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gapCnt_d = gapCnt_q + GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (uart_rx_done && (state_q inside {S_EXEC, S_RD, S_TX_GAP})) begin
         errEvent = 1'b1;
      end

      errCnt_d = (errEvent && (errCnt_q != 8'hFF)) ? errCnt_q + 8'd1 : errCnt_q;
   end

   assign tx_data       = txData_q;
   assign tx_start      = txStart_q;
   assign reg_addr      = addr_q;
   assign reg_wdata     = data_q;
   assign frame_err_cnt = errCnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; expected register strobes and response bytes
// are queued with their due cycle when a frame is sent and checked as the DUT emits them.
module tb_uart_cmd_parser;

   localparam int G = 20;
   localparam int T = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       uart_rx_done = 1'b0;
   logic [7:0] reg_rdata = 8'h00;
   logic [7:0] tx_data;
   logic       tx_start;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] frame_err_cnt;

   uart_cmd_parser #(.TX_GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .uart_rx_done (uart_rx_done),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_we       (reg_we),
      .reg_re       (reg_re),
      .reg_rdata    (reg_rdata),
      .frame_err_cnt(frame_err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int expErr = 0;

   typedef struct {
      logic [7:0] data;
      int         due;
   } txExp_t;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         due;
   } regExp_t;

   txExp_t  txQ[$];
   regExp_t regQ[$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      rx_data      = b;
      uart_rx_done = 1'b1;
      @(negedge clk);
      uart_rx_done = 1'b0;
   endtask

   task automatic waitCycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   // The last byte is driven inline so expectations are queued in its own cycle,
   // before the DUT can react.
   task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] chk);
      logic ok;
      int   n;
      applyStimulus(8'h55);
      applyStimulus(cmd);
      applyStimulus(addr);
      applyStimulus(data);
      @(negedge clk);
      rx_data      = chk;
      uart_rx_done = 1'b1;
      n  = cyc;
      ok = (chk == (cmd ^ addr ^ data)) && ((cmd == 8'h01) || (cmd == 8'h02));
      if (!ok) begin
         if (expErr < 255) expErr++;
         txQ.push_back('{8'hEE, n + 2});
      end else if (cmd == 8'h01) begin
         regQ.push_back('{1'b1, addr, data, n + 1});
         txQ.push_back('{8'hA0, n + 2});
      end else begin
         regQ.push_back('{1'b0, addr, 8'h00, n + 1});
         txQ.push_back('{8'hA1, n + 2});
         txQ.push_back('{reg_rdata, n + 2 + G});
      end
      @(negedge clk);
      uart_rx_done = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
      checkOutput({tag, "_tx_start"}, {31'h0, tx_start}, 32'h0);
      checkOutput({tag, "_reg_addr"}, {24'h0, reg_addr}, 32'h0);
      checkOutput({tag, "_reg_wdata"}, {24'h0, reg_wdata}, 32'h0);
      checkOutput({tag, "_reg_we"}, {31'h0, reg_we}, 32'h0);
      checkOutput({tag, "_reg_re"}, {31'h0, reg_re}, 32'h0);
      checkOutput({tag, "_err_cnt"}, {24'h0, frame_err_cnt}, 32'h0);
   endtask

   // Scoreboard side: every strobe must match the oldest queued expectation, including its cycle.
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         checks++;
         assert (txQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL unexpected_tx: observed tx_start data %0h at cycle %0d expected none", tx_data, cyc);
         end
         if (txQ.size() > 0) begin
            txExp_t e;
            e = txQ.pop_front();
            checkOutput("tx_data", {24'h0, tx_data}, {24'h0, e.data});
            checkOutput("tx_cycle", cyc, e.due);
         end
      end
      if ((reg_we === 1'b1) || (reg_re === 1'b1)) begin
         checks++;
         assert (regQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL unexpected_reg: observed we=%0b re=%0b addr %0h at cycle %0d expected none",
                   reg_we, reg_re, reg_addr, cyc);
         end
         if (regQ.size() > 0) begin
            regExp_t r;
            r = regQ.pop_front();
            checkOutput("reg_we", {31'h0, reg_we}, {31'h0, r.we});
            checkOutput("reg_re", {31'h0, reg_re}, {31'h0, !r.we});
            checkOutput("reg_addr", {24'h0, reg_addr}, {24'h0, r.addr});
            if (r.we) checkOutput("reg_wdata", {24'h0, reg_wdata}, {24'h0, r.wdata});
            checkOutput("reg_cycle", cyc, r.due);
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      waitCycles(3);
      checkAllZero("reset");
      rst_n = 1'b1;
      waitCycles(2);

      sendFrame(8'h01, 8'h10, 8'h3C, 8'h2D);
      waitCycles(G + 5);
      checkOutput("err_after_write", {24'h0, frame_err_cnt}, expErr);

      reg_rdata = 8'h5A;
      sendFrame(8'h02, 8'h22, 8'h00, 8'h20);
      waitCycles(2 * G + 5);
      checkOutput("err_after_read", {24'h0, frame_err_cnt}, expErr);

      sendFrame(8'h01, 8'h10, 8'h3C, 8'h00);
      waitCycles(G + 5);
      checkOutput("err_bad_chk", {24'h0, frame_err_cnt}, expErr);

      sendFrame(8'h07, 8'h00, 8'h00, 8'h07);
      waitCycles(G + 5);
      checkOutput("err_bad_cmd", {24'h0, frame_err_cnt}, expErr);

      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      waitCycles(3);
      checkOutput("err_stray", {24'h0, frame_err_cnt}, expErr);

      // Partial frame: last byte at cycle b, error must appear exactly at b+T, not before.
      applyStimulus(8'h55);
      applyStimulus(8'h01);
      waitCycles(T - 2);
      checkOutput("timeout_early", {24'h0, frame_err_cnt}, expErr);
      waitCycles(1);
      expErr++;
      checkOutput("timeout_err", {24'h0, frame_err_cnt}, expErr);

      sendFrame(8'h01, 8'hAB, 8'hCD, 8'h67);
      waitCycles(G + 5);
      checkOutput("err_resync", {24'h0, frame_err_cnt}, expErr);

      sendFrame(8'h01, 8'h40, 8'h99, 8'hD8);
      waitCycles(5);
      applyStimulus(8'h55);
      expErr++;
      waitCycles(G + 5);
      checkOutput("err_dropped_byte", {24'h0, frame_err_cnt}, expErr);

      for (int i = 0; i < 300; i++) begin
         sendFrame(8'h01, 8'h10, 8'h3C, 8'h00);
         waitCycles(G + 2);
      end
      checkOutput("err_saturated", {24'h0, frame_err_cnt}, expErr);

      reg_rdata = 8'h77;
      sendFrame(8'h02, 8'h33, 8'h00, 8'h31);
      waitCycles(6);
      rst_n = 1'b0;
      #1;
      checkAllZero("mid_reset");
      void'(txQ.pop_back());
      expErr = 0;
      waitCycles(3);
      rst_n = 1'b1;
      waitCycles(G + 5);

      sendFrame(8'h01, 8'h55, 8'hAA, 8'hFE);
      waitCycles(G + 5);
      checkOutput("err_after_reset", {24'h0, frame_err_cnt}, expErr);

      checkOutput("tx_queue_drained", txQ.size(), 0);
      checkOutput("reg_queue_drained", regQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
